// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM stage: word/register widths, latch layouts and bubbles.
// Optional feature macro used by this slice: MISALIGN_TRAP_EN.
package mem_stage_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  reg_sel_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic reg_write;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{
    mem_read:   1'b0,
    mem_write:  1'b0,
    mem_to_reg: 1'b0,
    reg_write:  1'b0
  };

  typedef struct packed {
    word_t    addr;
    word_t    store_data;
    reg_sel_t sel;
    ctrl_t    ctrl;
  } ex_mem_t;

  localparam ex_mem_t EX_MEM_BUBBLE = '{
    addr:       32'h0000_0000,
    store_data: 32'h0000_0000,
    sel:        5'd0,
    ctrl:       CTRL_BUBBLE
  };

  typedef struct packed {
    word_t    wb_data;
    reg_sel_t sel;
    logic     reg_write;
  } mem_wb_t;

  localparam mem_wb_t MEM_WB_BUBBLE = '{
    wb_data:   32'h0000_0000,
    sel:       5'd0,
    reg_write: 1'b0
  };

  // Register $zero is never written, so its write enable is dropped as early as possible.
  function automatic logic gate_reg_write(input logic reg_write, input reg_sel_t sel);
    return reg_write & (sel != 5'd0);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Bundle between execute/forwarding/hazard logic (master) and the MEM stage (slave).
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic     stall;
  logic     flush;
  word_t    ALUresult;
  word_t    busBpreMux;
  reg_sel_t regWriteSel;
  logic     memRead;
  logic     memWrite;
  logic     memToReg;
  logic     regWrite;

  word_t    address;
  logic     memRead_XM;
  reg_sel_t regWriteSel_XM;
  logic     regWrite_XM;
  word_t    nextOutput;
  reg_sel_t regWriteSel_MW;
  logic     regWrite_MW;
  logic     misalign;

  modport master (
    output stall, flush, ALUresult, busBpreMux, regWriteSel,
           memRead, memWrite, memToReg, regWrite,
    input  address, memRead_XM, regWriteSel_XM, regWrite_XM,
           nextOutput, regWriteSel_MW, regWrite_MW, misalign
  );

  modport slave (
    input  stall, flush, ALUresult, busBpreMux, regWriteSel,
           memRead, memWrite, memToReg, regWrite,
    output address, memRead_XM, regWriteSel_XM, regWrite_XM,
           nextOutput, regWriteSel_MW, regWrite_MW, misalign
  );

endinterface

// File: rtl/mem_stage_dmem.sv
// Word-addressed data memory: combinational read, write on the rising edge.
// Contents are deliberately not reset.
module mem_stage_dmem
  import mem_stage_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clock,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] idx_i,
  input  word_t                 wdata_i,
  output word_t                 rdata_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  word_t mem_q [DEPTH];

  // Synchronous write port
  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/mem_stage.sv
// EX/MEM latch, data memory access and MEM/WB latch of the 5-stage pipeline.
// Define MISALIGN_TRAP_EN to suppress misaligned accesses and raise a sticky misalign flag.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic          clock,
  input  logic          reset,
  mem_stage_if.slave    bus
);

  ex_mem_t               ex_mem_q, ex_mem_d;
  mem_wb_t               mem_wb_q, mem_wb_d;
  logic [DEPTH_LOG2-1:0] idx_s;
  word_t                 rdata_s;
  word_t                 load_data_s;
  logic                  misaligned_s;
  logic                  we_s;

  // EX/MEM next state: flush beats stall
  always_comb begin
    ex_mem_d = ex_mem_q;
    if (bus.flush) begin
      ex_mem_d = EX_MEM_BUBBLE;
    end else if (bus.stall) begin
      ex_mem_d = ex_mem_q;
    end else begin
      ex_mem_d.addr            = bus.ALUresult;
      ex_mem_d.store_data      = bus.busBpreMux;
      ex_mem_d.sel             = bus.regWriteSel;
      ex_mem_d.ctrl.mem_read   = bus.memRead;
      ex_mem_d.ctrl.mem_write  = bus.memWrite;
      ex_mem_d.ctrl.mem_to_reg = bus.memToReg;
      ex_mem_d.ctrl.reg_write  = gate_reg_write(bus.regWrite, bus.regWriteSel);
    end
  end

  // Upper address bits beyond the array wrap; byte offset is handled by the trap logic
  assign idx_s = ex_mem_q.addr[DEPTH_LOG2+1:2];

`ifdef MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  assign misaligned_s = (ex_mem_q.ctrl.mem_read | ex_mem_q.ctrl.mem_write) &
                        (ex_mem_q.addr[1:0] != 2'b00);

  // Sticky trap flag
  always_comb begin
    misalign_d = misalign_q | misaligned_s;
  end

  // Trap flag register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign bus.misalign = misalign_q;
`else
  assign misaligned_s = 1'b0;
  assign bus.misalign = 1'b0;
`endif

  // A held store writes only on the edge where stall drops
  assign we_s = ex_mem_q.ctrl.mem_write & ~bus.stall & ~misaligned_s;

  mem_stage_dmem #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_dmem (
    .clock   (clock),
    .we_i    (we_s),
    .idx_i   (idx_s),
    .wdata_i (ex_mem_q.store_data),
    .rdata_o (rdata_s)
  );

  assign load_data_s = misaligned_s ? 32'h0000_0000 : rdata_s;

  // MEM/WB next state: a stall leaves a bubble behind the held instruction
  always_comb begin
    mem_wb_d = MEM_WB_BUBBLE;
    if (bus.stall) begin
      mem_wb_d = MEM_WB_BUBBLE;
    end else begin
      mem_wb_d.wb_data   = ex_mem_q.ctrl.mem_to_reg ? load_data_s : ex_mem_q.addr;
      mem_wb_d.sel       = ex_mem_q.sel;
      mem_wb_d.reg_write = ex_mem_q.ctrl.reg_write;
    end
  end

  // Pipeline latches
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ex_mem_q <= EX_MEM_BUBBLE;
      mem_wb_q <= MEM_WB_BUBBLE;
    end else begin
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  assign bus.address        = ex_mem_q.addr;
  assign bus.memRead_XM     = ex_mem_q.ctrl.mem_read;
  assign bus.regWriteSel_XM = ex_mem_q.sel;
  assign bus.regWrite_XM    = ex_mem_q.ctrl.reg_write;
  assign bus.nextOutput     = mem_wb_q.wb_data;
  assign bus.regWriteSel_MW = mem_wb_q.sel;
  assign bus.regWrite_MW    = mem_wb_q.reg_write;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected writebacks are queued at issue, a monitor pops them.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  mem_stage_if bus ();

  mem_stage #(.DEPTH_LOG2(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  sel;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] b, input logic [4:0] sel,
                       input logic mr, input logic mw, input logic m2r, input logic rw);
    bus.ALUresult   = alu;
    bus.busBpreMux  = b;
    bus.regWriteSel = sel;
    bus.memRead     = mr;
    bus.memWrite    = mw;
    bus.memToReg    = m2r;
    bus.regWrite    = rw;
  endtask

  task automatic nop();
    drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_wb(input logic [31:0] d, input logic [4:0] s);
    exp_t e;
    e.data = d;
    e.sel  = s;
    exp_q.push_back(e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_address"},     bus.address,                 32'h0);
    chk({tag, "_memRead_XM"},  {31'h0, bus.memRead_XM},     32'h0);
    chk({tag, "_sel_XM"},      {27'h0, bus.regWriteSel_XM}, 32'h0);
    chk({tag, "_regWrite_XM"}, {31'h0, bus.regWrite_XM},    32'h0);
    chk({tag, "_nextOutput"},  bus.nextOutput,              32'h0);
    chk({tag, "_sel_MW"},      {27'h0, bus.regWriteSel_MW}, 32'h0);
    chk({tag, "_regWrite_MW"}, {31'h0, bus.regWrite_MW},    32'h0);
    chk({tag, "_misalign"},    {31'h0, bus.misalign},       32'h0);
  endtask

  // Monitor: every asserted regWrite_MW must match the oldest queued writeback
  always @(negedge clock) begin
    if (!reset && bus.regWrite_MW === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got data 0x%08h rd %0d, expected no writeback",
                 bus.nextOutput, bus.regWriteSel_MW);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.nextOutput !== e.data || bus.regWriteSel_MW !== e.sel) begin
          errors++;
          $display("FAIL wb_data: got 0x%08h rd %0d expected 0x%08h rd %0d",
                   bus.nextOutput, bus.regWriteSel_MW, e.data, e.sel);
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    nop();
    repeat (2) tick();
    chk_all_zero("reset");
    reset = 1'b0;

    // Known value at 0x80 for the reset-mid-store case later
    drive(32'h80, 32'h1234_5678, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();

    // Plain ALU result through both latches
    drive(32'h1234, 32'h0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_wb(32'h1234, 5'd5);
    tick();
    chk("alu_address",     bus.address,                 32'h1234);
    chk("alu_sel_XM",      {27'h0, bus.regWriteSel_XM}, 32'd5);
    chk("alu_regWrite_XM", {31'h0, bus.regWrite_XM},    32'd1);

    // Store then load of the same word
    drive(32'h40, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("alu_nextOutput",  bus.nextOutput,              32'h1234);
    chk("alu_regWrite_MW", {31'h0, bus.regWrite_MW},    32'd1);
    drive(32'h40, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1);
    expect_wb(32'hDEAD_BEEF, 5'd8);
    tick();
    chk("ld_memRead_XM",   {31'h0, bus.memRead_XM},     32'd1);

    // Writes to $zero are dropped in both latches
    drive(32'h55, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("r0_regWrite_XM",  {31'h0, bus.regWrite_XM},    32'd0);
    chk("ld_nextOutput",   bus.nextOutput,              32'hDEAD_BEEF);
    nop();
    tick();
    chk("r0_regWrite_MW",  {31'h0, bus.regWrite_MW},    32'd0);
    tick();

    // Held store: no write and MEM/WB bubbles while stalled, one write when released
    drive(32'h40, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(32'h40, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_address",     bus.address,              32'h40);
      chk("stall_regWrite_MW", {31'h0, bus.regWrite_MW}, 32'd0);
      chk("stall_nextOutput",  bus.nextOutput,           32'h0);
      chk("stall_mem_held",    dut.u_dmem.mem_q[16],     32'hDEAD_BEEF);
    end
    bus.stall = 1'b0;
    expect_wb(32'hCAFE_F00D, 5'd9);
    tick();
    chk("stall_mem_written", dut.u_dmem.mem_q[16],       32'hCAFE_F00D);
    chk("stall_ld_in_XM",    {31'h0, bus.memRead_XM},    32'd1);
    nop();
    repeat (2) tick();

    // Flush wins over stall
    drive(32'h100, 32'h0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1);
    bus.flush = 1'b1;
    bus.stall = 1'b1;
    tick();
    chk("flush_memRead_XM",  {31'h0, bus.memRead_XM},    32'd0);
    chk("flush_regWrite_XM", {31'h0, bus.regWrite_XM},   32'd0);
    chk("flush_address",     bus.address,                32'h0);
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    nop();
    repeat (2) tick();

    // Misaligned store, then aligned and misaligned loads of the same word
    drive(32'h42, 32'h0BAD_F00D, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(32'h40, 32'h0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1);
`ifdef MISALIGN_TRAP_EN
    expect_wb(32'hCAFE_F00D, 5'd11);
`else
    expect_wb(32'h0BAD_F00D, 5'd11);
`endif
    tick();
`ifdef MISALIGN_TRAP_EN
    chk("mis_mem",  dut.u_dmem.mem_q[16],     32'hCAFE_F00D);
    chk("mis_flag", {31'h0, bus.misalign},    32'd1);
`else
    chk("mis_mem",  dut.u_dmem.mem_q[16],     32'h0BAD_F00D);
    chk("mis_flag", {31'h0, bus.misalign},    32'd0);
`endif
    drive(32'h42, 32'h0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b1);
`ifdef MISALIGN_TRAP_EN
    expect_wb(32'h0, 5'd12);
`else
    expect_wb(32'h0BAD_F00D, 5'd12);
`endif
    tick();
    nop();
    repeat (3) tick();

    // Reset while a store sits in MEM: outputs clear at once, store is lost
    drive(32'h80, 32'h7777_7777, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    nop();
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("midrst");
    tick();
    reset = 1'b0;
    drive(32'h80, 32'h0, 5'd13, 1'b1, 1'b0, 1'b1, 1'b1);
    expect_wb(32'h1234_5678, 5'd13);
    tick();
    nop();
    repeat (3) tick();

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
